pipe_stage_reg: RTL and testbench
=================================

# pipe_stage_reg

Parametrised elastic pipeline stage register: the next generation of the per-stage pipeline latches between DECODE/EXE/MEM/WB. It carries an arbitrary-width payload plus an end-of-instruction (EOI) bit. It adds a valid/ready handshake with a 2-entry skid buffer, so back-pressure never creates a combinational ready path across stages. It keeps the legacy stall/flush semantics: stall overrides flush, and flushed or empty slots read as all-zero bubbles.

## Interface
Parameters:
- DATA_W, 64, payload width in bits (≥1)
- DBG_W, 40, debug sideband width (used only with PIPE_STAGE_DEBUG_EN)

Ports:
- CLK  in  1  clock; all state updates on posedge
- RST  in  1  reset; one clock, synchronous, active-high
- in_valid  in  1  upstream beat present
- in_ready  out  1  stage accepts beat this cycle
- in_data  in  DATA_W  upstream payload
- in_eoi  in  1  upstream end-of-instruction flag
- flush  in  1  discard all held beats
- stall  in  1  global hold; overrides flush
- out_valid  out  1  downstream beat present
- out_ready  in  1  downstream accepts beat
- out_data  out  DATA_W  payload to downstream
- out_eoi  out  1  EOI to downstream
- DEBUG_in  in  DBG_W  debug sideband (macro only)
- DEBUG_out  out  DBG_W  debug sideband out (macro only)
- stall_cycles  out  16  saturating back-pressure counter (macro only)

## Operation
- Storage: main entry (drives outputs) and skid entry. Each entry holds data, eoi and, when enabled, debug.
- States:
  - EMPTY: no beat held.
  - ONE: main valid, skid empty.
  - FULL: both valid.
- State, in_ready and out_valid are registered. in_ready and out_valid are masked combinationally only by stall and flush.
- Outputs and handshake:
  - in_ready = (state != FULL) & ~stall & ~flush.
  - out_valid = (state != EMPTY) & ~stall.
  - out_data/out_eoi always reflect the main entry.
  - in_fire = in_valid & in_ready.
  - out_fire = out_valid & out_ready.
- Priority: RST > stall > flush > normal.
  - stall=1: no state or data change, no transfers on either side. Counter still runs (see Configuration).
  - flush=1 & stall=0: next state EMPTY; both entries cleared to zero. A concurrent in_valid beat is dropped (in_ready=0). A concurrent out_ready gets no transfer.
- Normal transitions (stall=0, flush=0):
  - EMPTY: in_fire → ONE, main←in.
  - ONE: in_fire & ~out_fire → FULL, skid←in.
  - ONE: in_fire & out_fire → ONE, main←in.
  - ONE: ~in_fire & out_fire → EMPTY, main←0.
  - FULL: out_fire → ONE, main←skid, skid←0. No input is accepted in FULL.
- Invariant: any entry not holding a valid beat contains all zeros, so out_data=0 and out_eoi=0 whenever state=EMPTY.
- Ordering: beats leave in arrival order; none duplicated or lost except by flush.

## Timing
- Reset: state EMPTY, both entries 0, in_ready=1, out_valid=0, out_data=0, out_eoi=0, DEBUG_out=0, stall_cycles=0.
- Latency: a beat accepted at edge N is visible on out_* after edge N; out_valid=1 in cycle N+1.
- Throughput: 1 beat/cycle while out_ready=1.
- Back-pressure: after out_ready drops, at most one more beat is accepted (into skid); in_ready is low from the next cycle.
- Release: when out_ready rises in FULL, in_ready returns to 1 one cycle later.
- RST asserted mid-operation discards all held beats at that edge, regardless of stall or flush.
- stall and flush both asserted: stall wins; flush is ignored that cycle and is not remembered.

## Configuration
- PIPE_STAGE_DEBUG_EN defined:
  - DEBUG_in/DEBUG_out ports exist and travel through both entries with identical valid, flush and zero rules.
  - stall_cycles increments each cycle where stall=1, or state!=EMPTY & ~out_ready & ~flush.
  - stall_cycles saturates at 16'hFFFF; cleared only by RST.
- Not defined: DEBUG_in, DEBUG_out and stall_cycles ports and logic are absent; all other behaviour is identical.

## Test plan
- Reset, then in_valid=1, data=0xA5, eoi=1, out_ready=1 → out_valid=1, out_data=0xA5, out_eoi=1 one cycle later; in_ready stays 1.
- Stream 0x1..0x8 with out_ready=1 → 8 consecutive out beats 0x1..0x8, no bubbles.
- Stream with out_ready=0 from cycle 2 → beats 0x1, 0x2 held; in_ready=0 from cycle 3. out_ready=1 → 0x1 then 0x2 delivered in order, and in_ready=1 one cycle after release.
- FULL with stall=1 and flush=1 together for 3 cycles → out_valid=0, in_ready=0, contents retained. Drop stall, keep flush 1 cycle → EMPTY, out_data=0.
- RST during FULL with stall=1 → next cycle EMPTY, in_ready=1, all outputs 0.
- PIPE_STAGE_DEBUG_EN: out_ready=0 with one held beat for 70000 cycles → stall_cycles=0xFFFF; DEBUG_out equals the held beat's DEBUG_in.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// Elastic pipeline stage: main + skid entry behind a valid/ready handshake, with stall/flush control.
// Define PIPE_STAGE_DEBUG_EN to add the DEBUG_in/DEBUG_out sideband and the stall_cycles counter.
module pipe_stage_reg #(
   parameter int DATA_W = 64,
   parameter int DBG_W  = 40
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_eoi,
   input  logic              flush,
   input  logic              stall,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_eoi
`ifdef PIPE_STAGE_DEBUG_EN
   ,
   input  logic [DBG_W-1:0]  DEBUG_in,
   output logic [DBG_W-1:0]  DEBUG_out,
   output logic [15:0]       stall_cycles
`endif
);

   typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic              eoi;
`ifdef PIPE_STAGE_DEBUG_EN
      logic [DBG_W-1:0]  dbg;
`endif
   } entry_t;

   state_t state, state_n;
   entry_t main_q, main_n;
   entry_t skid_q, skid_n;
   entry_t in_ent;
   logic   in_fire, out_fire;

`ifdef PIPE_STAGE_DEBUG_EN
   assign in_ent = '{data: in_data, eoi: in_eoi, dbg: DEBUG_in};
`else
   assign in_ent = '{data: in_data, eoi: in_eoi};
`endif

   // Handshake is a function of registered state only; stall/flush are the sole combinational masks.
   assign in_ready  = (state != FULL) & ~stall & ~flush;
   assign out_valid = (state != EMPTY) & ~stall;
   assign in_fire   = in_valid & in_ready;
   assign out_fire  = out_valid & out_ready;

   assign out_data = main_q.data;
   assign out_eoi  = main_q.eoi;

   always_ff @(posedge CLK) begin
      if (RST) begin
         state  <= EMPTY;
         main_q <= '0;
         skid_q <= '0;
      end else begin
         state  <= state_n;
         main_q <= main_n;
         skid_q <= skid_n;
      end
   end

   // Vacated entries are zeroed so an empty slot always reads as a bubble.
   always_comb begin
      state_n = state;
      main_n  = main_q;
      skid_n  = skid_q;
      if (!stall) begin
         if (flush) begin
            state_n = EMPTY;
            main_n  = '0;
            skid_n  = '0;
         end else begin
            unique case (state)
               EMPTY: begin
                  if (in_fire) begin
                     state_n = ONE;
                     main_n  = in_ent;
                  end
               end
               ONE: begin
                  if (in_fire && !out_fire) begin
                     state_n = FULL;
                     skid_n  = in_ent;
                  end else if (in_fire && out_fire) begin
                     main_n  = in_ent;
                  end else if (out_fire) begin
                     state_n = EMPTY;
                     main_n  = '0;
                  end
               end
               FULL: begin
                  if (out_fire) begin
                     state_n = ONE;
                     main_n  = skid_q;
                     skid_n  = '0;
                  end
               end
               default: begin
                  state_n = EMPTY;
                  main_n  = '0;
                  skid_n  = '0;
               end
            endcase
         end
      end
   end

`ifdef PIPE_STAGE_DEBUG_EN
   assign DEBUG_out = main_q.dbg;

   logic cnt_inc;
   assign cnt_inc = stall | ((state != EMPTY) & ~out_ready & ~flush);

   always_ff @(posedge CLK) begin
      if (RST)
         stall_cycles <= '0;
      else if (cnt_inc && stall_cycles != 16'hFFFF)
         stall_cycles <= stall_cycles + 16'd1;
   end
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed self-checking bench for pipe_stage_reg; debug-counter scenario runs when PIPE_STAGE_DEBUG_EN is defined.
module tb_pipe_stage_reg;

   localparam int DATA_W = 64;
   localparam int DBG_W  = 40;

   logic              CLK = 1'b0;
   logic              RST;
   logic              in_valid, in_ready;
   logic [DATA_W-1:0] in_data;
   logic              in_eoi;
   logic              flush, stall;
   logic              out_valid, out_ready;
   logic [DATA_W-1:0] out_data;
   logic              out_eoi;
`ifdef PIPE_STAGE_DEBUG_EN
   logic [DBG_W-1:0]  DEBUG_in, DEBUG_out;
   logic [15:0]       stall_cycles;
`endif

   int vectors = 0;
   int errs    = 0;

   always #5 CLK = ~CLK;

   pipe_stage_reg #(.DATA_W(DATA_W), .DBG_W(DBG_W)) dut (
      .CLK(CLK), .RST(RST),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_eoi(in_eoi),
      .flush(flush), .stall(stall),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_eoi(out_eoi)
`ifdef PIPE_STAGE_DEBUG_EN
      , .DEBUG_in(DEBUG_in), .DEBUG_out(DEBUG_out), .stall_cycles(stall_cycles)
`endif
   );

   // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic do_reset();
      RST = 1'b1; in_valid = 1'b0; in_data = '0; in_eoi = 1'b0;
      flush = 1'b0; stall = 1'b0; out_ready = 1'b0;
`ifdef PIPE_STAGE_DEBUG_EN
      DEBUG_in = '0;
`endif
      step();
      RST = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      do_reset();
      vectors++; if (in_ready !== 1'b1) begin errs++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
      vectors++; if (out_valid !== 1'b0) begin errs++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
      vectors++; if (out_data !== 64'h0) begin errs++; $display("FAIL reset_out_data got %h want 0", out_data); end
      vectors++; if (out_eoi !== 1'b0) begin errs++; $display("FAIL reset_out_eoi got %b want 0", out_eoi); end
`ifdef PIPE_STAGE_DEBUG_EN
      vectors++; if (stall_cycles !== 16'h0) begin errs++; $display("FAIL reset_stall_cycles got %h want 0", stall_cycles); end
      vectors++; if (DEBUG_out !== '0) begin errs++; $display("FAIL reset_debug_out got %h want 0", DEBUG_out); end
`endif
   endtask

   task automatic test_single();
      in_valid = 1'b1; in_data = 64'hA5; in_eoi = 1'b1; out_ready = 1'b1;
      step();
      in_valid = 1'b0; in_data = '0; in_eoi = 1'b0;
      #1;
      vectors++; if (out_valid !== 1'b1) begin errs++; $display("FAIL single_valid got %b want 1", out_valid); end
      vectors++; if (out_data !== 64'hA5) begin errs++; $display("FAIL single_data got %h want a5", out_data); end
      vectors++; if (out_eoi !== 1'b1) begin errs++; $display("FAIL single_eoi got %b want 1", out_eoi); end
      vectors++; if (in_ready !== 1'b1) begin errs++; $display("FAIL single_in_ready got %b want 1", in_ready); end
      step();
      vectors++; if (out_valid !== 1'b0 || out_data !== 64'h0) begin errs++; $display("FAIL single_drain got v=%b d=%h want v=0 d=0", out_valid, out_data); end
   endtask

   task automatic test_stream();
      out_ready = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         in_valid = 1'b1; in_data = 64'(i); in_eoi = i[0];
         step();
         vectors++; if (out_valid !== 1'b1 || out_data !== 64'(i) || out_eoi !== i[0])
            begin errs++; $display("FAIL stream_beat%0d got v=%b d=%h e=%b want v=1 d=%h e=%b", i, out_valid, out_data, out_eoi, i, i[0]); end
         vectors++; if (in_ready !== 1'b1) begin errs++; $display("FAIL stream_in_ready%0d got %b want 1", i, in_ready); end
      end
      in_valid = 1'b0; in_data = '0; in_eoi = 1'b0;
      step();
      vectors++; if (out_valid !== 1'b0) begin errs++; $display("FAIL stream_end got %b want 0", out_valid); end
   endtask

   task automatic test_back_to_back();
      out_ready = 1'b1; in_valid = 1'b1; in_data = 64'h1;
      step();
      out_ready = 1'b0; in_data = 64'h2;
      step();
      in_data = 64'h3;
      #1;
      vectors++; if (in_ready !== 1'b0) begin errs++; $display("FAIL bp_in_ready got %b want 0", in_ready); end
      vectors++; if (out_data !== 64'h1 || out_valid !== 1'b1) begin errs++; $display("FAIL bp_head got v=%b d=%h want v=1 d=1", out_valid, out_data); end
      step();
      vectors++; if (in_ready !== 1'b0 || out_data !== 64'h1) begin errs++; $display("FAIL bp_hold got rdy=%b d=%h want rdy=0 d=1", in_ready, out_data); end
      in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
      #1;
      vectors++; if (in_ready !== 1'b0) begin errs++; $display("FAIL bp_release_same_cycle got %b want 0", in_ready); end
      step();
      vectors++; if (out_data !== 64'h2 || out_valid !== 1'b1) begin errs++; $display("FAIL bp_second got v=%b d=%h want v=1 d=2", out_valid, out_data); end
      vectors++; if (in_ready !== 1'b1) begin errs++; $display("FAIL bp_release got %b want 1", in_ready); end
      step();
      vectors++; if (out_valid !== 1'b0 || out_data !== 64'h0) begin errs++; $display("FAIL bp_drain got v=%b d=%h want v=0 d=0", out_valid, out_data); end
   endtask

   task automatic fill_full();
      out_ready = 1'b0; in_valid = 1'b1; in_data = 64'h11; in_eoi = 1'b1;
      step();
      in_data = 64'h22; in_eoi = 1'b0;
      step();
      in_valid = 1'b0; in_data = '0;
   endtask

   task automatic test_stall_flush();
      fill_full();
      stall = 1'b1; flush = 1'b1; out_ready = 1'b1;
      #1;
      vectors++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin errs++; $display("FAIL sf_mask got v=%b rdy=%b want 0 0", out_valid, in_ready); end
      repeat (3) step();
      vectors++; if (out_data !== 64'h11 || out_eoi !== 1'b1 || out_valid !== 1'b0)
         begin errs++; $display("FAIL sf_retain got v=%b d=%h e=%b want v=0 d=11 e=1", out_valid, out_data, out_eoi); end
      stall = 1'b0;
      step();
      flush = 1'b0; out_ready = 1'b0;
      #1;
      vectors++; if (out_valid !== 1'b0 || out_data !== 64'h0 || out_eoi !== 1'b0)
         begin errs++; $display("FAIL flush_empty got v=%b d=%h e=%b want 0 0 0", out_valid, out_data, out_eoi); end
      vectors++; if (in_ready !== 1'b1) begin errs++; $display("FAIL flush_in_ready got %b want 1", in_ready); end
   endtask

   task automatic test_reset_mid();
      fill_full();
      stall = 1'b1; RST = 1'b1;
      step();
      RST = 1'b0; stall = 1'b0;
      #1;
      vectors++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errs++; $display("FAIL rst_mid_hs got rdy=%b v=%b want 1 0", in_ready, out_valid); end
      vectors++; if (out_data !== 64'h0 || out_eoi !== 1'b0) begin errs++; $display("FAIL rst_mid_data got d=%h e=%b want 0 0", out_data, out_eoi); end
      out_ready = 1'b1;
      step();
      vectors++; if (out_valid !== 1'b0) begin errs++; $display("FAIL rst_mid_skid got %b want 0", out_valid); end
      out_ready = 1'b0;
   endtask

`ifdef PIPE_STAGE_DEBUG_EN
   task automatic test_debug();
      do_reset();
      in_valid = 1'b1; in_data = 64'h5; DEBUG_in = 40'hAB_CDEF_0123;
      step();
      in_valid = 1'b0; in_data = '0; DEBUG_in = 40'h11_2233_4455;
      #1;
      vectors++; if (DEBUG_out !== 40'hAB_CDEF_0123) begin errs++; $display("FAIL dbg_out got %h want abcdef0123", DEBUG_out); end
      vectors++; if (stall_cycles !== 16'h0) begin errs++; $display("FAIL dbg_cnt_start got %h want 0", stall_cycles); end
      step();
      vectors++; if (stall_cycles !== 16'h1) begin errs++; $display("FAIL dbg_cnt_one got %h want 1", stall_cycles); end
      repeat (70000) @(posedge CLK);
      #1;
      vectors++; if (stall_cycles !== 16'hFFFF) begin errs++; $display("FAIL dbg_cnt_sat got %h want ffff", stall_cycles); end
      vectors++; if (DEBUG_out !== 40'hAB_CDEF_0123 || out_data !== 64'h5) begin errs++; $display("FAIL dbg_held got dbg=%h d=%h want abcdef0123 5", DEBUG_out, out_data); end
   endtask
`endif

   initial begin
      test_reset();
      test_single();
      test_stream();
      test_back_to_back();
      test_stall_flush();
      test_reset_mid();
`ifdef PIPE_STAGE_DEBUG_EN
      test_debug();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end

endmodule
